// File: rtl/periph_tx_initiator_if.sv
// Store-path write port and send/ack peripheral handshake of the transmit initiator.
interface periph_tx_initiator_if;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic [15:0] dado;
    logic [1:0]  send;
    logic [1:0]  ack;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  sent_count;

    modport master (
        input  wr_en, wr_data, ack,
        output full, dado, send, busy, timeout_err, sent_count
    );

    modport slave (
        output wr_en, wr_data, ack,
        input  full, dado, send, busy, timeout_err, sent_count
    );
endinterface

// File: rtl/periph_tx_initiator.sv
// Buffers datapath words in a FIFO and sends each one to the peripheral
// over a 4-phase send/ack handshake with a bounded wait for acknowledge.
module periph_tx_initiator #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    periph_tx_initiator_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = 16;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [TW-1:0] timer;
    logic [15:0]   dado_q;
    logic [1:0]    send_q;
    logic          err_q;
    logic [7:0]    cnt_q;

    logic full_int;
    logic empty;
    logic push;
    logic load;

    // Full is judged on the registered count, so a same-cycle pop never frees room for a write.
    assign full_int = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = bus.wr_en && !full_int;
    assign load     = !empty && ((state == IDLE) || (state == RELEASE && bus.ack == 2'b00));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            timer  <= '0;
            dado_q <= '0;
            send_q <= 2'b00;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(load);

            // A load can happen from IDLE or straight out of RELEASE, skipping IDLE.
            if (load) begin
                dado_q <= mem[rd_ptr];
                send_q <= 2'b01;
                timer  <= '0;
                state  <= REQ;
            end else begin
                case (state)
                    REQ: begin
                        if (bus.ack == 2'b01) begin
                            send_q <= 2'b00;
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= RELEASE;
                        end else if (timer == TW'(TIMEOUT - 1)) begin
                            send_q <= 2'b00;
                            err_q  <= 1'b1;
                            state  <= RELEASE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    RELEASE: begin
                        if (bus.ack == 2'b00) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.full        = full_int;
    assign bus.busy        = (state != IDLE) || !empty;
    assign bus.dado        = dado_q;
    assign bus.send        = send_q;
    assign bus.timeout_err = err_q;
    assign bus.sent_count  = cnt_q;
endmodule

// File: tb/tb_periph_tx_initiator.sv
// Randomized and directed bench for periph_tx_initiator against a queue-based transaction model.
module tb_periph_tx_initiator;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    periph_tx_initiator_if bus();

    periph_tx_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: pending words in a queue, plus the word currently on the wire.
    logic [15:0] mq[$];
    bit          m_req  = 1'b0;
    bit          m_rel  = 1'b0;
    int          m_wait = 0;
    logic [15:0] m_dado = '0;
    logic [1:0]  m_send = 2'b00;
    logic        m_err  = 1'b0;
    logic [7:0]  m_cnt  = '0;

    // 0: peripheral echoes send one cycle late, 1: ack held at 00, 2: echo with random glitches.
    int          ack_mode  = 0;
    int          rise_t[$];
    logic [15:0] rise_d[$];
    logic [1:0]  last_send = 2'b00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    endtask

    task automatic model_edge(input logic we, input logic [15:0] wd, input logic [1:0] ak, input logic r);
        int n0;
        bit full0;
        if (r) begin
            mq.delete();
            m_req  = 1'b0;
            m_rel  = 1'b0;
            m_wait = 0;
            m_dado = '0;
            m_send = 2'b00;
            m_err  = 1'b0;
            m_cnt  = '0;
        end else begin
            n0    = mq.size();
            full0 = (n0 == DEPTH);
            if (m_req) begin
                if (ak == 2'b01) begin
                    m_cnt  = m_cnt + 8'd1;
                    m_req  = 1'b0;
                    m_rel  = 1'b1;
                    m_send = 2'b00;
                end else if (m_wait == TIMEOUT) begin
                    m_err  = 1'b1;
                    m_req  = 1'b0;
                    m_rel  = 1'b1;
                    m_send = 2'b00;
                end else begin
                    m_wait++;
                end
            end else if (!m_rel || ak == 2'b00) begin
                m_rel = 1'b0;
                if (n0 > 0) begin
                    m_dado = mq.pop_front();
                    m_send = 2'b01;
                    m_req  = 1'b1;
                    m_wait = 1;
                end
            end
            if (we && !full0) mq.push_back(wd);
        end
    endtask

    task automatic step();
        logic [1:0] s_prev;
        s_prev = m_send;
        model_edge(bus.wr_en, bus.wr_data, bus.ack, rst);
        @(posedge clk);
        #1;
        cyc++;
        chk("send",  32'(bus.send),        32'(m_send));
        chk("dado",  32'(bus.dado),        32'(m_dado));
        chk("full",  32'(bus.full),        32'(mq.size() == DEPTH));
        chk("busy",  32'(bus.busy),        32'(m_req || m_rel || mq.size() != 0));
        chk("err",   32'(bus.timeout_err), 32'(m_err));
        chk("count", 32'(bus.sent_count),  32'(m_cnt));
        if (bus.send == 2'b01 && last_send != 2'b01) begin
            rise_t.push_back(cyc);
            rise_d.push_back(bus.dado);
        end
        last_send  = bus.send;
        bus.wr_en  = 1'b0;
        case (ack_mode)
            0:       bus.ack = s_prev;
            1:       bus.ack = 2'b00;
            default: bus.ack = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : s_prev;
        endcase
    endtask

    task automatic wr(input logic [15:0] w);
        bus.wr_en   = 1'b1;
        bus.wr_data = w;
        step();
    endtask

    task automatic run(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step();
            if (bus.send == 2'b01) hi++;
        end
    endtask

    initial begin
        int hi;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.ack     = 2'b00;

        rst = 1'b1;
        step();
        step();
        chk("rst_send",  32'(bus.send),        32'd0);
        chk("rst_dado",  32'(bus.dado),        32'd0);
        chk("rst_busy",  32'(bus.busy),        32'd0);
        chk("rst_full",  32'(bus.full),        32'd0);
        chk("rst_count", 32'(bus.sent_count),  32'd0);
        rst = 1'b0;

        // Single word through an echoing peripheral
        ack_mode = 0;
        wr(16'hBEEF);
        run(10, hi);
        chk("single_hi",    32'(hi),             32'd2);
        chk("single_count", 32'(bus.sent_count), 32'd1);
        chk("single_busy",  32'(bus.busy),       32'd0);

        // Back-to-back words
        rise_t.delete();
        rise_d.delete();
        wr(16'h0001);
        wr(16'h0002);
        wr(16'h0003);
        run(20, hi);
        chk("b2b_n",     32'(rise_d.size()),    32'd3);
        for (int i = 0; i < rise_d.size(); i++) chk("b2b_dado", 32'(rise_d[i]), 32'(i + 1));
        for (int i = 1; i < rise_t.size(); i++) chk("b2b_gap", 32'(rise_t[i] - rise_t[i-1]), 32'd4);
        chk("b2b_count", 32'(bus.sent_count),   32'd4);

        // Overflow with ack held off, then released before the wait limit
        rise_t.delete();
        rise_d.delete();
        ack_mode = 1;
        for (int i = 0; i < 6; i++) wr(16'(16'hA0 + i));
        chk("ovf_full", 32'(bus.full), 32'd1);
        ack_mode = 0;
        run(40, hi);
        chk("ovf_n", 32'(rise_d.size()), 32'd5);
        for (int i = 0; i < rise_d.size(); i++) chk("ovf_order", 32'(rise_d[i]), 32'(16'hA0 + i));
        chk("ovf_err",   32'(bus.timeout_err), 32'd0);
        chk("ovf_count", 32'(bus.sent_count),  32'd9);

        // Reset during a request
        wr(16'h1111);
        wr(16'h2222);
        chk("mid_req_pre", 32'(bus.send), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_send",  32'(bus.send),       32'd0);
        chk("mid_busy",  32'(bus.busy),       32'd0);
        chk("mid_count", 32'(bus.sent_count), 32'd0);
        run(10, hi);
        chk("mid_quiet", 32'(hi), 32'd0);

        // Handshake abort on missing acknowledge
        ack_mode = 1;
        wr(16'h1234);
        run(15, hi);
        chk("to_hi",    32'(hi),              32'(TIMEOUT));
        chk("to_err",   32'(bus.timeout_err), 32'd1);
        chk("to_count", 32'(bus.sent_count),  32'd0);
        ack_mode = 0;
        wr(16'h5678);
        run(10, hi);
        chk("to_next_hi",    32'(hi),              32'd2);
        chk("to_next_count", 32'(bus.sent_count),  32'd1);
        chk("to_sticky",     32'(bus.timeout_err), 32'd1);

        // Counter wraps after 256 handshakes
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wr(16'(i));
            run(3, hi);
        end
        run(20, hi);
        chk("wrap_count", 32'(bus.sent_count),  32'd0);
        chk("wrap_err",   32'(bus.timeout_err), 32'd0);

        // Random traffic, glitchy acknowledge and occasional reset
        ack_mode = 2;
        repeat (3000) begin
            bus.wr_en   = ($urandom_range(0, 9) < 4);
            bus.wr_data = 16'($urandom);
            rst         = ($urandom_range(0, 299) == 0);
            step();
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
